// File: rtl/layer_argmax_if.sv
// rtl/layer_argmax_if.sv - Avalon-MM master bus plus ready/done handshake for layer_argmax
//
// Purpose : bundles the SDRAM-side Avalon-MM signals and the sequencer-side
//           ready/done handshake of the argmax stage into one port.
// Signals :
//   waitrequest   slave -> master  slave stall, command held while high
//   readdatavalid slave -> master  read data strobe
//   readdata      slave -> master  16-bit signed score
//   read_n        master -> slave  active-low read command
//   write_n       master -> slave  active-low write command
//   chipselect    master -> slave  high while any command is driven
//   address       master -> slave  byte address of the command
//   byteenable    master -> slave  2'b11 during commands, 2'b00 otherwise
//   writedata     master -> slave  result word {zero pad, class_idx}
//   ready         sequencer -> master  start request (level)
//   done          master -> sequencer  run complete, held until ready drops
//   class_idx     master -> sequencer  winning index
//   max_val       master -> sequencer  winning score
interface layer_argmax_if #(
  parameter int IDX_W = 4
) ();
  logic             waitrequest;
  logic             readdatavalid;
  logic [15:0]      readdata;
  logic             read_n;
  logic             write_n;
  logic             chipselect;
  logic [31:0]      address;
  logic [1:0]       byteenable;
  logic [15:0]      writedata;
  logic             ready;
  logic             done;
  logic [IDX_W-1:0] class_idx;
  logic [15:0]      max_val;

  modport master (
    input  waitrequest, readdatavalid, readdata, ready,
    output read_n, write_n, chipselect, address, byteenable, writedata,
    output done, class_idx, max_val
  );

  modport slave (
    output waitrequest, readdatavalid, readdata, ready,
    input  read_n, write_n, chipselect, address, byteenable, writedata,
    input  done, class_idx, max_val
  );
endinterface

// File: rtl/layer_argmax.sv
// rtl/layer_argmax.sv - argmax over N_OUT signed scores read from SDRAM, index written back
//
// Purpose : after the final layer, reads N_OUT signed 16-bit scores starting at
//           SRC_BASE, tracks the maximum (lowest index wins ties), writes the
//           winning index to DST_ADDR and raises done.
// Ports   :
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    layer_argmax_if.master  Avalon-MM master + ready/done handshake
module layer_argmax #(
  parameter int          N_OUT    = 10,
  parameter int          IDX_W    = 4,
  parameter logic [31:0] SRC_BASE = 32'h0008_0000,
  parameter logic [31:0] DST_ADDR = 32'h0008_0100
) (
  input logic            clk,
  input logic            reset,
  layer_argmax_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_class_idx;
  logic [15:0]      r_max_val;
  logic             r_read_n;
  logic             r_write_n;
  logic             r_chipselect;
  logic [31:0]      r_address;
  logic [1:0]       r_byteenable;
  logic [15:0]      r_writedata;
  logic             r_done;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_class_nxt;
  logic [15:0]      w_max_nxt;
  logic             w_read_n_nxt;
  logic             w_write_n_nxt;
  logic             w_cs_nxt;
  logic [31:0]      w_address_nxt;
  logic [1:0]       w_be_nxt;
  logic [15:0]      w_wdata_nxt;
  logic             w_done_nxt;
  logic             w_take;

  // Next-state and datapath. Bus outputs are registered and derived from the
  // next state, so a stalled command (waitrequest=1) keeps state and idx and
  // therefore reproduces exactly the same command values every cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_class_nxt = r_class_idx;
    w_max_nxt   = r_max_val;
    w_take      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.ready) begin
          w_state_nxt = S_RD_REQ;
          w_idx_nxt   = '0;
          w_class_nxt = '0;
          w_max_nxt   = '0;
        end
      end
      S_RD_REQ: begin
        if (!bus.waitrequest) begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // readdatavalid is only meaningful here; anywhere else it is ignored.
        if (bus.readdatavalid) begin
          // Element 0 seeds the running maximum; strict > keeps the lowest
          // index on ties.
          w_take = (r_idx == '0) || ($signed(bus.readdata) > $signed(r_max_val));
          if (w_take) begin
            w_max_nxt   = bus.readdata;
            w_class_nxt = r_idx;
          end
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_WR;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_RD_REQ;
          end
        end
      end
      S_WR: begin
        if (!bus.waitrequest) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // No auto-restart: the sequencer must drop ready before a new run.
        if (!bus.ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_read_n_nxt  = (w_state_nxt != S_RD_REQ);
    w_write_n_nxt = (w_state_nxt != S_WR);
    w_cs_nxt      = !w_read_n_nxt || !w_write_n_nxt;
    w_be_nxt      = w_cs_nxt ? 2'b11 : 2'b00;
    w_done_nxt    = (w_state_nxt == S_DONE);

    w_address_nxt = 32'h0;
    w_wdata_nxt   = 16'h0;
    if (w_state_nxt == S_RD_REQ) begin
      w_address_nxt = SRC_BASE + (32'(w_idx_nxt) << 1);
    end else if (w_state_nxt == S_WR) begin
      w_address_nxt = DST_ADDR;
      w_wdata_nxt   = 16'(w_class_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_class_idx  <= '0;
      r_max_val    <= 16'h0;
      r_read_n     <= 1'b1;
      r_write_n    <= 1'b1;
      r_chipselect <= 1'b0;
      r_address    <= 32'h0;
      r_byteenable <= 2'b00;
      r_writedata  <= 16'h0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_class_idx  <= w_class_nxt;
      r_max_val    <= w_max_nxt;
      r_read_n     <= w_read_n_nxt;
      r_write_n    <= w_write_n_nxt;
      r_chipselect <= w_cs_nxt;
      r_address    <= w_address_nxt;
      r_byteenable <= w_be_nxt;
      r_writedata  <= w_wdata_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign bus.read_n     = r_read_n;
  assign bus.write_n    = r_write_n;
  assign bus.chipselect = r_chipselect;
  assign bus.address    = r_address;
  assign bus.byteenable = r_byteenable;
  assign bus.writedata  = r_writedata;
  assign bus.done       = r_done;
  assign bus.class_idx  = r_class_idx;
  assign bus.max_val    = r_max_val;

endmodule
